// File: rtl/fetch_unit_pkg.sv
// Shared constants for the fetch stage.
//   - Default widths and reset PC used by fetch_unit and icache_dm.
//   - FSM state encodings for the fetch miss handshake.
package fetch_unit_pkg;

    localparam int unsigned DefAddrW   = 32;
    localparam int unsigned DefDataW   = 32;
    localparam int unsigned DefIdxW    = 8;
    localparam logic [31:0] DefResetPc = 32'h0000_0000;

    // Fetch FSM states
    localparam logic [1:0] StIdle = 2'd0; // look up the cache at pc
    localparam logic [1:0] StMiss = 2'd1; // request outstanding, pc still wanted
    localparam logic [1:0] StDrop = 2'd2; // request outstanding, pc redirected away

endpackage

// File: rtl/icache_dm.sv
// Direct-mapped instruction cache, one word per line.
//   clk, reset : clock, async active-high reset (clears valid bits only)
//   inval      : clear every valid bit on the next edge; wins over a same-edge write
//   rd_line    : word address (byte address >> 2) to look up
//   rd_hit     : combinational hit for rd_line
//   rd_data    : combinational data at rd_line's index
//   wr_en      : write wr_data and tag of wr_line, mark line valid
//   wr_line    : word address being filled
//   wr_data    : fill data
module icache_dm
    import fetch_unit_pkg::*;
#(
    parameter int unsigned ADDR_W = DefAddrW,
    parameter int unsigned DATA_W = DefDataW,
    parameter int unsigned IDX_W  = DefIdxW
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              inval,
    input  logic [ADDR_W-3:0] rd_line,
    output logic              rd_hit,
    output logic [DATA_W-1:0] rd_data,
    input  logic              wr_en,
    input  logic [ADDR_W-3:0] wr_line,
    input  logic [DATA_W-1:0] wr_data
);

    localparam int unsigned Depth = 2 ** IDX_W;
    localparam int unsigned TagW  = ADDR_W - 2 - IDX_W;

    logic [Depth-1:0]  valid_q;
    logic [TagW-1:0]   tag_mem  [Depth];
    logic [DATA_W-1:0] data_mem [Depth];

    logic [IDX_W-1:0] rd_idx;
    logic [TagW-1:0]  rd_tag;
    logic [IDX_W-1:0] wr_idx;
    logic [TagW-1:0]  wr_tag;

    assign rd_idx = rd_line[IDX_W-1:0];
    assign rd_tag = rd_line[ADDR_W-3:IDX_W];
    assign wr_idx = wr_line[IDX_W-1:0];
    assign wr_tag = wr_line[ADDR_W-3:IDX_W];

    assign rd_hit  = valid_q[rd_idx] && (tag_mem[rd_idx] == rd_tag);
    assign rd_data = data_mem[rd_idx];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
        end else if (inval) begin
            valid_q <= '0;
        end else if (wr_en) begin
            valid_q[wr_idx] <= 1'b1;
        end
    end

    // Tag/data arrays carry no reset; a line is meaningless until its valid bit is set.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_mem[wr_idx]  <= wr_tag;
            data_mem[wr_idx] <= wr_data;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage with an integrated direct-mapped cache.
//   clk, reset          : clock, async active-high reset
//   rdy                 : low freezes every register (cache included)
//   mc_req, mc_addr     : registered miss request to the memory controller
//   mc_valid, mc_data   : one-cycle fill response
//   redirect, redirect_pc : load a new fetch PC and flush the output slot
//   inval               : invalidate the whole cache
//   out_valid/out_ready : one-entry valid/ready output to issue
//   out_instr, out_pc   : fetched instruction and its PC
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int unsigned       ADDR_W   = DefAddrW,
    parameter int unsigned       DATA_W   = DefDataW,
    parameter int unsigned       IDX_W    = DefIdxW,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DefResetPc)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rdy,
    output logic              mc_req,
    output logic [ADDR_W-1:0] mc_addr,
    input  logic              mc_valid,
    input  logic [DATA_W-1:0] mc_data,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              inval,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_instr,
    output logic [ADDR_W-1:0] out_pc
);

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_instr_q, out_instr_d;
    logic [ADDR_W-1:0] out_pc_q, out_pc_d;
    logic              mc_req_q, mc_req_d;
    logic [ADDR_W-1:0] mc_addr_q, mc_addr_d;

    logic              cache_hit;
    logic [DATA_W-1:0] cache_data;
    logic              lookup_hit;
    logic              slot_free;
    logic              fill;

    // Fills always target mc_addr_q, which still names the requested line after a redirect.
    icache_dm #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .IDX_W  (IDX_W)
    ) u_icache (
        .clk     (clk),
        .reset   (reset),
        .inval   (inval && rdy),
        .rd_line (pc_q[ADDR_W-1:2]),
        .rd_hit  (cache_hit),
        .rd_data (cache_data),
        .wr_en   (fill && rdy),
        .wr_line (mc_addr_q[ADDR_W-1:2]),
        .wr_data (mc_data)
    );

    // A lookup racing an invalidate must not return a line that is about to vanish.
    assign lookup_hit = cache_hit && !inval;
    assign slot_free  = !out_valid_q || out_ready;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        out_valid_d = out_valid_q;
        out_instr_d = out_instr_q;
        out_pc_d    = out_pc_q;
        mc_req_d    = mc_req_q;
        mc_addr_d   = mc_addr_q;
        fill        = 1'b0;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            StIdle: begin
                if (!redirect) begin
                    if (lookup_hit) begin
                        if (slot_free) begin
                            out_valid_d = 1'b1;
                            out_instr_d = cache_data;
                            out_pc_d    = pc_q;
                            pc_d        = pc_q + ADDR_W'(4);
                        end
                    end else begin
                        state_d   = StMiss;
                        mc_req_d  = 1'b1;
                        mc_addr_d = pc_q;
                    end
                end
            end
            StMiss: begin
                if (mc_valid) begin
                    fill     = 1'b1;
                    state_d  = StIdle;
                    mc_req_d = 1'b0;
                end else if (redirect) begin
                    state_d  = StDrop;
                    mc_req_d = 1'b0;
                end
            end
            StDrop: begin
                // The returning word is still correct for its own address, so keep it.
                if (mc_valid) begin
                    fill    = 1'b1;
                    state_d = StIdle;
                end
            end
            default: begin
                state_d  = StIdle;
                mc_req_d = 1'b0;
            end
        endcase

        if (redirect) begin
            pc_d        = redirect_pc;
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            pc_q        <= RESET_PC;
            out_valid_q <= 1'b0;
            out_instr_q <= '0;
            out_pc_q    <= '0;
            mc_req_q    <= 1'b0;
            mc_addr_q   <= '0;
        end else if (rdy) begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            out_valid_q <= out_valid_d;
            out_instr_q <= out_instr_d;
            out_pc_q    <= out_pc_d;
            mc_req_q    <= mc_req_d;
            mc_addr_q   <= mc_addr_d;
        end
    end

    assign mc_req    = mc_req_q;
    assign mc_addr   = mc_addr_q;
    assign out_valid = out_valid_q;
    assign out_instr = out_instr_q;
    assign out_pc    = out_pc_q;

endmodule
